// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - command/response sequencer driving a combinational 16-bit ALU
// Optional result self-check enabled by defining ALU_SEQ_CHECK_EN.
module alu_cmd_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_zero,
    output logic             resp_err,
    output logic             resp_mismatch,
    output logic             mismatch_sticky,
    output logic [15:0]      txn_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             err;
    logic             accept;
    logic             handshake;
    logic             legal_op;
    logic [WIDTH-1:0] captured;

    // Ready is gated by rst_n so it reads 0 for the whole reset window.
    assign cmd_ready  = rst_n && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = cmd_valid && cmd_ready;
    assign handshake  = (state == RESP) && resp_ready;
    assign legal_op   = (cmd_op <= 3'b100);
    assign captured   = err ? '0 : alu_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (handshake) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= 3'b000;
            err         <= 1'b0;
            resp_data   <= '0;
            resp_zero   <= 1'b0;
            resp_err    <= 1'b0;
            txn_count   <= 16'd0;
        end else begin
            if (accept) begin
                alu_a       <= cmd_a;
                alu_b       <= cmd_b;
                alu_control <= legal_op ? cmd_op : 3'b000;
                err         <= !legal_op;
            end
            if (state == EXEC) begin
                resp_data <= captured;
                resp_zero <= (captured == '0);
                resp_err  <= err;
            end
            if (handshake) begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end

`ifdef ALU_SEQ_CHECK_EN
    logic [WIDTH-1:0] expected;
    logic             mismatch_now;

    always_comb begin
        expected = '0;
        case (alu_control)
            3'b000:  expected = alu_a + alu_b;
            3'b001:  expected = alu_a - alu_b;
            3'b010:  expected = alu_a & alu_b;
            3'b011:  expected = alu_a | alu_b;
            3'b100:  expected = alu_a ^ alu_b;
            default: expected = '0;
        endcase
    end

    assign mismatch_now = !err && (alu_result != expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_mismatch   <= 1'b0;
            mismatch_sticky <= 1'b0;
        end else if (state == EXEC) begin
            resp_mismatch <= mismatch_now;
            if (mismatch_now) begin
                mismatch_sticky <= 1'b1;
            end
        end
    end
`else
    assign resp_mismatch   = 1'b0;
    assign mismatch_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a queue-based response model
module tb_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_a = '0;
    logic [15:0] cmd_b = '0;
    logic [2:0]  cmd_op = '0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_control;
    logic [15:0] alu_result;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic        resp_zero;
    logic        resp_err;
    logic        resp_mismatch;
    logic        mismatch_sticky;
    logic [15:0] txn_count;

    logic        force_en = 1'b0;
    logic [15:0] force_val = '0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] d;
        logic        z;
        logic        e;
        logic        m;
    } exp_t;

    exp_t        exp_q[$];
    int          exp_cnt = 0;
    logic        exp_sticky = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_zero(resp_zero), .resp_err(resp_err),
        .resp_mismatch(resp_mismatch), .mismatch_sticky(mismatch_sticky),
        .txn_count(txn_count)
    );

    function automatic logic [15:0] alu_fn(logic [15:0] a, logic [15:0] b, logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 16'h0000;
        endcase
    endfunction

    // Stand-in ALU, with an override used to provoke a mismatch.
    assign alu_result = force_en ? force_val : alu_fn(alu_a, alu_b, alu_control);

    function automatic exp_t predict(logic [15:0] a, logic [15:0] b, logic [2:0] op);
        exp_t        x;
        logic [15:0] r;
        r   = alu_fn(a, b, op);
        x.e = (op > 3'd4);
        x.d = x.e ? 16'h0000 : (force_en ? force_val : r);
        x.z = (x.d == 16'h0000);
`ifdef ALU_SEQ_CHECK_EN
        x.m = !x.e && (x.d != r);
`else
        x.m = 1'b0;
`endif
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_cmd_ready", cmd_ready, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_alu_a", alu_a, 0);
            chk("rst_alu_b", alu_b, 0);
            chk("rst_alu_control", alu_control, 0);
            chk("rst_resp_data", resp_data, 0);
            chk("rst_flags", {resp_zero, resp_err, resp_mismatch, mismatch_sticky}, 0);
            chk("rst_txn_count", txn_count, 0);
        end else begin
            chk("txn_count", txn_count, exp_cnt);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", resp_valid, 0);
                end else begin
                    if (exp_q[0].m) exp_sticky = 1'b1;
                    chk("resp_data", resp_data, exp_q[0].d);
                    chk("resp_zero", resp_zero, exp_q[0].z);
                    chk("resp_err", resp_err, exp_q[0].e);
                    chk("resp_mismatch", resp_mismatch, exp_q[0].m);
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        exp_cnt = (exp_cnt + 1) % 65536;
                    end
                end
            end
            chk("mismatch_sticky", mismatch_sticky, exp_sticky);
        end
    end

    // Presents a command and returns 1ns after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        bit done = 0;
        @(posedge clk);
        #1;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                exp_q.push_back(predict(a, b, op));
                #1;
                cmd_valid = 1'b0;
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        exp_sticky = 1'b0;
        #1;
        chk("async_resp_valid", resp_valid, 0);
        chk("async_txn_count", txn_count, 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1);

        resp_ready = 1'b1;
        send(16'h1234, 16'h5678, 3'b000);
        @(negedge clk);
        chk("exec_resp_valid", resp_valid, 0);
        chk("exec_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        chk("lat_resp_valid", resp_valid, 1);
        chk("lit_add", resp_data, 16'h68AC);
        @(negedge clk);
        chk("lit_txn1", txn_count, 1);
        chk("back_idle", cmd_ready, 1);

        send(16'hFFFF, 16'h0001, 3'b000);
        @(negedge clk);
        @(negedge clk);
        chk("lit_wrap_data", resp_data, 16'h0000);
        chk("lit_wrap_zero", resp_zero, 1);
        send(16'h5678, 16'h1234, 3'b001);
        @(negedge clk);
        @(negedge clk);
        chk("lit_sub", resp_data, 16'h4444);
        send(16'h00FF, 16'h0F0F, 3'b010);
        send(16'h00F0, 16'h0F00, 3'b011);
        drain();

        resp_ready = 1'b0;
        send(16'hF0F0, 16'h0F0F, 3'b100);
        #1;
        cmd_a = 16'h1111; cmd_b = 16'h2222; cmd_op = 3'b000; cmd_valid = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", resp_valid, 1);
            chk("bp_data", resp_data, 16'hFFFF);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_done_valid", resp_valid, 0);
        chk("bp_done_ready", cmd_ready, 1);

        send(16'hAAAA, 16'h5555, 3'b110);
        @(negedge clk);
        chk("ill_alu_control", alu_control, 0);
        @(negedge clk);
        chk("lit_ill_err", resp_err, 1);
        chk("lit_ill_data", resp_data, 16'h0000);
        drain();

        send(16'h0003, 16'h0004, 3'b000);
        do_reset();
        repeat (6) @(negedge clk);
        send(16'h0003, 16'h0004, 3'b000);
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_data", resp_data, 16'h0007);
        drain();

`ifdef ALU_SEQ_CHECK_EN
        force_en = 1'b1;
        force_val = 16'h0000;
        send(16'hAAAA, 16'h5555, 3'b011);
        @(negedge clk);
        @(negedge clk);
        chk("lit_mm", resp_mismatch, 1);
        chk("lit_sticky", mismatch_sticky, 1);
        drain();
        force_en = 1'b0;
        send(16'h0001, 16'h0001, 3'b000);
        drain();
        chk("sticky_held", mismatch_sticky, 1);
        @(posedge clk);
        do_reset();
        @(negedge clk);
        chk("sticky_cleared", mismatch_sticky, 0);
`endif

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator side of the 16-bit ALU operand/control interface (A, B, 3-bit control -> result).
- Accepts operation commands over a valid/ready handshake and drives registered operands and control into the combinational ALU.
- Captures the ALU result one cycle later and returns it, with status, over a valid/ready response handshake.
- Sits between a command source (CPU-side or test driver) and the ALU.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.

Ports:
- clk  input  1  clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- cmd_op  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor; 101-111 illegal
- alu_a  output  WIDTH  registered operand A to ALU
- alu_b  output  WIDTH  registered operand B to ALU
- alu_control  output  3  registered op to ALU
- alu_result  input  WIDTH  ALU result (combinational from alu_a/alu_b/alu_control)
- resp_valid  output  1  response present
- resp_ready  input  1  consumer accepts response
- resp_data  output  WIDTH  captured result
- resp_zero  output  1  resp_data == 0
- resp_err  output  1  command had an illegal op
- resp_mismatch  output  1  result differed from internal model (optional feature)
- mismatch_sticky  output  1  any mismatch since reset (optional feature)
- txn_count  output  16  completed responses, modulo 2^16

Behaviour:
- Reset is asynchronous, active-low, and applies at any time, including mid-transaction.
  - State returns to IDLE; any in-flight command is dropped with no response.
  - All outputs go to 0: cmd_ready=0 while rst_n=0, alu_a=alu_b=0, alu_control=000, resp_valid=0, resp_data=0, all flags 0, txn_count=0.
  - cmd_ready returns to 1 in IDLE after reset deasserts.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge k: register cmd_a/cmd_b into alu_a/alu_b.
  - Legal op: alu_control=cmd_op. Illegal op: alu_control=000 and the internal err flag is set.
  - Go to EXEC.
- EXEC (exactly one cycle):
  - cmd_ready=0; the ALU settles.
  - At edge k+1: resp_data=alu_result (forced to 0 if err); resp_zero=(captured value==0); resp_err=err; resp_valid=1; go to RESP.
- RESP:
  - cmd_ready=0.
  - resp_valid, resp_data and all flags are held stable until resp_valid&resp_ready.
  - On that edge: resp_valid=0, txn_count increments (FFFF->0000 wraps), go to IDLE.
  - No command is accepted on the same edge; the next accept is possible one edge later.
- Latency: response visible from edge k+1, one cycle after acceptance. Maximum throughput is one command per 3 cycles with resp_ready held at 1.
- alu_a/alu_b/alu_control keep their last values after a transaction until the next accept.
- Arithmetic: add/sub wrap modulo 2^WIDTH; no carry or overflow output.
- cmd_valid while cmd_ready=0 is ignored; the source must hold the command until it is accepted.
- resp_ready while resp_valid=0 has no effect.

Optional Feature:
- Macro: ALU_SEQ_CHECK_EN.
- Defined:
  - An internal reference model computes the expected result from the registered operands and op.
  - At capture, resp_mismatch=(alu_result != expected) for legal ops, and 0 for illegal ops.
  - mismatch_sticky is set on the first mismatch and cleared only by reset.
- Undefined: resp_mismatch and mismatch_sticky are tied to 0 and no model logic is instantiated. Ports exist in both builds.

Test Plan:
- A=1234, B=5678, op=000, resp_ready=1:
  - resp_valid rises one cycle after accept with resp_data=68AC, zero=0, err=0.
  - txn_count=1 after handshake.
- A=FFFF, B=0001, op=000 -> resp_data=0000, resp_zero=1 (wrap). Then A=5678, B=1234, op=001 -> 4444.
- Backpressure:
  - A=F0F0, B=0F0F, op=100 with resp_ready=0 for 5 cycles: resp_valid and resp_data=FFFF held, cmd_ready=0 throughout, new cmd_valid ignored.
  - Raise resp_ready: one handshake, then IDLE.
- Illegal op=110 with A=AAAA, B=5555 -> alu_control=000, resp_data=0000, resp_err=1, resp_zero=1, resp_mismatch=0.
- Reset mid-op: assert rst_n=0 during EXEC -> immediate resp_valid=0, txn_count=0, no response after release; next command completes normally.
- ALU_SEQ_CHECK_EN: force alu_result=0000 for A=AAAA, B=5555, op=011 -> resp_mismatch=1, mismatch_sticky=1 and held until reset.
